spdif_bmc_decoder: RTL
======================

# spdif_bmc_decoder

Receive-side counterpart of the S/PDIF BMC encoder. Samples a biphase-mark-coded line once per `clk128` cycle, one sample per half-cell. It acquires subframe alignment from the preambles, checks for BMC violations, and delivers decoded time slots as 4-bit nibbles over a valid/ready handshake. It sits between the line input, or an encoder in loopback, and the subframe/frame parser.

## Interface
- No parameters.
- `clk128`  in  1  128·fs clock; one line sample per cycle.
- `reset`  in  1  synchronous, active-high reset.
- `spdif`  in  1  BMC line. Already synchronous to `clk128`; registered once on entry.
- `o_valid`  out  1  nibble available.
- `o_ready`  in  1  consumer accepts the nibble; transfer occurs when `o_valid && o_ready` at a rising edge.
- `o_data`  out  4  decoded bits of 4 slots. `o_data[0]` is the earliest slot. Forced to 0 on preamble nibbles.
- `o_preamble`  out  2  0 = data nibble, 1 = B, 2 = M, 3 = W. Non-zero only on the first nibble of a subframe.
- `o_locked`  out  1  subframe alignment held.
- `o_error`  out  1  one-cycle pulse on a BMC violation or a missing preamble.
- `is_overrun`  out  1  one-cycle pulse when a nibble is dropped.
- `o_parity_error`  out  1  one-cycle pulse on a parity failure (see Configuration).

## Operation
- **Input path:** `spdif` → input register `s` → 8-bit shift register `h[7:0]` (`h[0]` newest) of half-cells.
- **Preamble match:** polarity-independent. Matches `h[7:0]` against B = 11101000, M = 11100010, W = 11100100, or their bitwise complements; the leftmost bit is the oldest half-cell.
- **State HUNT:** `o_locked` = 0; nothing is emitted.
  - On a preamble match: emit the preamble nibble, set half-cell counter `hc` = 8, go to LOCKED.
- **State LOCKED:** `hc` counts 0..63 per subframe (64 half-cells = 32 slots).
  - Each bit occupies an even/odd half-cell pair; bit value = (even ≠ odd).
  - Violation: no transition at a cell boundary (first half equals the previous second half). It pulses `o_error`, the bit still decodes, and lock is kept.
  - Every 8 half-cells (`hc` = 15, 23, …, 63) a data nibble is emitted; there are 7 per subframe (slots 4–31).
  - At `hc` = 7 of the next subframe the shift register must match a preamble.
    - Match: emit the preamble nibble and continue.
    - No match: pulse `o_error`, go to HUNT, and emit nothing.
  - Expected preamble sequence is not enforced; B/M/W are reported as found.
- **Output buffer:** one entry.
  - When a nibble is produced while `o_valid` = 1 and no transfer occurs that cycle, the new nibble is dropped, the held nibble is kept, and `is_overrun` pulses.
  - Produce and transfer in the same cycle: the buffer is replaced and `o_valid` stays 1.
- **Reset mid-operation:** buffer cleared, state HUNT, `hc` = 0, `h` = 0.

## Timing
- Reset values: `o_valid`, `o_data`, `o_preamble`, `o_locked`, `o_error`, `is_overrun`, `o_parity_error` are all 0.
- Latency: `o_valid` rises 2 cycles after the last half-cell of a nibble is present on `spdif` (input register plus output register).
- `o_locked` rises in the same cycle as `o_valid` for the locking preamble. It falls in the cycle after a missed preamble is detected.
- `o_error` is aligned with the cycle its offending half-cell enters `h`, plus 1.
- Nominal throughput is one nibble per 8 cycles, so a consumer with `o_ready` tied high never overruns.
- `o_data`/`o_preamble` are stable while `o_valid` = 1 and not accepted.

## Configuration
- `SPDIF_BMC_DECODER_PARITY_CHECK_EN` defined:
  - Accumulates XOR of decoded slots 4–31 per subframe.
  - At `hc` = 63, `o_parity_error` pulses one cycle (aligned with the last data nibble's `o_valid` rise) if the XOR is 1.
  - The accumulator clears at each preamble.
- Undefined: `o_parity_error` is constant 0 and no accumulator is built.

## Structure
- Shared package `spdif_pkg`:
  - Preamble pattern constants (B, M, W, 8 bits).
  - Enum `preamble_t` {NONE = 0, B = 1, M = 2, W = 3}.
  - Subframe constants: 64 half-cells, 4 preamble slots.
- Sub-module `spdif_bmc_preamble_detector`: combinational. Takes `h[7:0]` and returns `preamble_t` (NONE if no match).
- The top holds the input register, the FSM, the counter, bit decode, and the output buffer.

## Test plan
- Reset: hold `reset` for 2 cycles → all outputs 0; idle line (`spdif` constant) → `o_locked` stays 0 and no `o_valid`.
- Loopback from `spdif_bmc_encoder`: B subframe with slots 4–31 = 0x9ABCDE5 (LSB first), `o_ready` = 1 → `o_preamble` = 1, then 7 nibbles 5, E, D, C, B, A, 9; `o_locked` = 1; no `o_error`.
- Inverted-polarity line with the same stream → identical nibbles; then an M preamble → `o_preamble` = 2.
- `o_ready` held 0 for 20 cycles after the first data nibble → `is_overrun` pulses twice; the held nibble is unchanged; the following nibble is accepted after `o_ready` = 1.
- Corrupt the next preamble into data-like half-cells → `o_error` pulse, `o_locked` falls, no `o_valid` until the next valid preamble relocks.
- With `SPDIF_BMC_DECODER_PARITY_CHECK_EN`: subframe with odd parity over slots 4–31 → one `o_parity_error` pulse; even parity → none.

Source files
------------

// File: rtl/spdif_pkg.sv
// -----------------------------------------------------------------------------
// spdif_pkg
// Shared definitions for the S/PDIF biphase-mark receive path:
//   - preamble half-cell patterns (B, M, W), oldest half-cell in bit 7
//   - preamble_t enum used on the decoder's preamble output
//   - subframe geometry (half-cells per subframe, preamble length in slots)
//   - decoder FSM state encoding and a BMC bit helper
// -----------------------------------------------------------------------------
package spdif_pkg;

  localparam logic [7:0] PRE_B_PAT = 8'b1110_1000;
  localparam logic [7:0] PRE_M_PAT = 8'b1110_0010;
  localparam logic [7:0] PRE_W_PAT = 8'b1110_0100;

  localparam int unsigned SUBFRAME_HALF_CELLS = 64;
  localparam int unsigned PREAMBLE_SLOTS      = 4;
  localparam int unsigned HC_W                = $clog2(SUBFRAME_HALF_CELLS);

  // Half-cell indices that drive the decoder's decisions.
  localparam logic [HC_W-1:0] HC_PRE_LAST   = HC_W'(2 * PREAMBLE_SLOTS - 1);
  localparam logic [HC_W-1:0] HC_FIRST_DATA = HC_W'(2 * PREAMBLE_SLOTS);
  localparam logic [HC_W-1:0] HC_LAST       = HC_W'(SUBFRAME_HALF_CELLS - 1);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    B    = 2'd1,
    M    = 2'd2,
    W    = 2'd3
  } preamble_t;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } dec_state_t;

  // A BMC cell carries a 1 when its two halves differ.
  function automatic logic bmc_bit(input logic first_half, input logic second_half);
    return first_half ^ second_half;
  endfunction

endpackage

// File: rtl/spdif_bmc_preamble_detector.sv
// -----------------------------------------------------------------------------
// spdif_bmc_preamble_detector
// Combinational, polarity-independent preamble matcher. Compares an 8 half-cell
// window against B/M/W and their complements.
// Ports:
//   h_i        in  8  half-cell window, bit 7 oldest, bit 0 newest
//   preamble_o out 2  NONE when no pattern matches, otherwise B/M/W
// -----------------------------------------------------------------------------
module spdif_bmc_preamble_detector
  import spdif_pkg::*;
(
  input  logic [7:0] h_i,
  output preamble_t  preamble_o
);

  always_comb begin
    preamble_o = NONE;
    if ((h_i == PRE_B_PAT) || (h_i == ~PRE_B_PAT)) begin
      preamble_o = B;
    end else if ((h_i == PRE_M_PAT) || (h_i == ~PRE_M_PAT)) begin
      preamble_o = M;
    end else if ((h_i == PRE_W_PAT) || (h_i == ~PRE_W_PAT)) begin
      preamble_o = W;
    end
  end

endmodule

// File: rtl/spdif_bmc_decoder.sv
// -----------------------------------------------------------------------------
// spdif_bmc_decoder
// S/PDIF biphase-mark receiver. Samples one half-cell per clk128 cycle,
// acquires subframe alignment from preambles, flags BMC violations and
// delivers decoded slots as 4-bit nibbles over a one-entry valid/ready buffer.
// Optional feature macro: SPDIF_BMC_DECODER_PARITY_CHECK_EN (even parity check
// over slots 4..31; when undefined o_parity_error is tied to 0).
// Ports:
//   clk128         in   1  128*fs clock, one line sample per cycle
//   reset          in   1  synchronous active-high reset
//   spdif          in   1  BMC line, already synchronous to clk128
//   o_valid        out  1  nibble available
//   o_ready        in   1  consumer accepts the nibble
//   o_data         out  4  decoded slots, bit 0 earliest; 0 on preamble nibbles
//   o_preamble     out  2  0 data nibble, 1 B, 2 M, 3 W
//   o_locked       out  1  subframe alignment held
//   o_error        out  1  pulse on BMC violation or missing preamble
//   is_overrun     out  1  pulse when a produced nibble is dropped
//   o_parity_error out  1  pulse on parity failure at end of subframe
// -----------------------------------------------------------------------------
module spdif_bmc_decoder
  import spdif_pkg::*;
(
  input  logic       clk128,
  input  logic       reset,
  input  logic       spdif,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [3:0] o_data,
  output logic [1:0] o_preamble,
  output logic       o_locked,
  output logic       o_error,
  output logic       is_overrun,
  output logic       o_parity_error
);

  // ---------------------------------------------------------------------------
  // Input register and half-cell history.
  // h_d is the 8-entry shift register's next contents ({older history, s_q});
  // all decisions look at h_d so that outputs land one register after the
  // input register. Only the seven older entries need to be stored.
  // ---------------------------------------------------------------------------
  logic       s_q;
  logic [6:0] h_q;
  logic [7:0] h_d;

  assign h_d = {h_q, s_q};

  always_ff @(posedge clk128) begin
    if (reset) begin
      s_q <= 1'b0;
      h_q <= '0;
    end else begin
      s_q <= spdif;
      h_q <= h_d[6:0];
    end
  end

  preamble_t pre_found;

  spdif_bmc_preamble_detector u_pre_det (
    .h_i        (h_d),
    .preamble_o (pre_found)
  );

  // ---------------------------------------------------------------------------
  // Nibble decode: four cells in the window, oldest cell lands in bit 0.
  // ---------------------------------------------------------------------------
  logic [3:0] nib;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = bmc_bit(h_d[7 - 2*gi], h_d[6 - 2*gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  dec_state_t state_q, state_d;
  logic [HC_W-1:0] hc_q, hc_d;

  logic locked_now;
  logic in_data;
  logic at_pre_check;
  logic at_nibble;
  logic violation;
  logic miss;
  logic pre_emit;

  always_ff @(posedge clk128) begin
    if (reset) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (pre_found != NONE) state_d = ST_LOCKED;
      ST_LOCKED: if (miss)              state_d = ST_HUNT;
      default:                          state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    o_locked = (state_q == ST_LOCKED);
  end

  // ---------------------------------------------------------------------------
  // Decision strobes. hc_q is the subframe index of the half-cell in s_q
  // (the newest entry of the window).
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_now   = (state_q == ST_LOCKED);
    in_data      = (hc_q >= HC_FIRST_DATA);
    at_pre_check = locked_now && (hc_q == HC_PRE_LAST);
    at_nibble    = locked_now && in_data && (hc_q[2:0] == 3'b111);
    // Even index = first half of a cell; it must differ from the previous
    // cell's second half. Preamble half-cells violate on purpose, so skip them.
    violation    = locked_now && in_data && !hc_q[0] && (s_q == h_q[0]);
    miss         = at_pre_check && (pre_found == NONE);
    pre_emit     = (pre_found != NONE) && (!locked_now || at_pre_check);
  end

  always_comb begin
    hc_d = hc_q;
    if (!locked_now) begin
      hc_d = (pre_found != NONE) ? HC_FIRST_DATA : '0;
    end else if (miss) begin
      hc_d = '0;
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // One-entry output buffer.
  // ---------------------------------------------------------------------------
  logic       valid_q, valid_d;
  logic [3:0] data_q, data_d;
  preamble_t  pre_q, pre_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;
  logic       produce;
  logic       xfer;

  always_comb begin
    produce = pre_emit || at_nibble;
    xfer    = valid_q && o_ready;
    valid_d = valid_q;
    data_d  = data_q;
    pre_d   = pre_q;
    ovr_d   = 1'b0;
    err_d   = violation || miss;
    if (produce && (!valid_q || xfer)) begin
      valid_d = 1'b1;
      data_d  = pre_emit ? 4'd0 : nib;
      pre_d   = pre_emit ? pre_found : NONE;
    end else if (produce) begin
      // Buffer full and not draining: keep the held nibble, drop the new one.
      ovr_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk128) begin
    if (reset) begin
      hc_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      pre_q   <= NONE;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      pre_q   <= pre_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_preamble = pre_q;
  assign o_error    = err_q;
  assign is_overrun = ovr_q;

  // ---------------------------------------------------------------------------
  // Optional parity check over slots 4..31 (slot 31 carries even parity).
  // ---------------------------------------------------------------------------
`ifdef SPDIF_BMC_DECODER_PARITY_CHECK_EN
  logic par_acc_q, par_acc_d;
  logic par_err_q, par_err_d;
  logic cell_bit;

  always_comb begin
    cell_bit  = bmc_bit(h_q[0], s_q);
    par_acc_d = par_acc_q;
    par_err_d = 1'b0;
    if (pre_emit) begin
      par_acc_d = 1'b0;
    end else if (locked_now && in_data && hc_q[0]) begin
      par_acc_d = par_acc_q ^ cell_bit;
      if (hc_q == HC_LAST) begin
        par_err_d = par_acc_q ^ cell_bit;
      end
    end
  end

  always_ff @(posedge clk128) begin
    if (reset) begin
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
    end
  end

  assign o_parity_error = par_err_q;
`else
  assign o_parity_error = 1'b0;
`endif

endmodule
